// File: rtl/serial_term_accumulator.sv
// Receives the serializer's signed-term stream and multiplies each term by its
// activation. It sums the products into a wide accumulator and hands out the group total with a valid/ready handshake.
module serial_term_accumulator #(
    parameter int ACT_W = 8,
    parameter int ACC_W = 24
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_last,
    input  logic                    sign,
    input  logic [1:0]              exp,
    input  logic                    mantissa,
    input  logic [2:0]              bsig,
    input  logic signed [ACT_W-1:0] act,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACC_W-1:0] result,
    output logic                    ovf,
    output logic [15:0]             term_count
);

    localparam int PP_W = ACT_W + 11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                  state_r;
    logic                    in_ready_r;
    logic                    out_valid_r;
    logic signed [ACC_W-1:0] acc_r;
    logic                    ovf_r;
    logic [15:0]             term_count_r;
    logic signed [PP_W-1:0]  pp_r;
    logic                    pp_valid_r;
    logic                    pp_last_r;

    logic                    accept_s;
    logic signed [ACC_W-1:0] pp_ext_s;
    logic signed [ACC_W-1:0] sum_s;
    logic                    add_ovf_s;

    // Signed partial product of one term: act shifted by exp+bsig, negated for
    // negative terms, zero when the mantissa bit is clear.
    function automatic logic signed [PP_W-1:0] term_product(
        input logic signed [ACT_W-1:0] a,
        input logic                    s,
        input logic [1:0]              e,
        input logic                    m,
        input logic [2:0]              b
    );
        logic signed [PP_W-1:0] mag;
        logic [3:0]             sh;
        sh  = {2'b00, e} + {1'b0, b};
        mag = PP_W'(a) <<< sh;
        if (!m) begin
            term_product = '0;
        end else if (s) begin
            term_product = -mag;
        end else begin
            term_product = mag;
        end
    endfunction

    // in_ready_r is only high in ACCUM before the last term, so it also
    // serves as the "last term not yet seen" flag.
    assign accept_s = in_valid & in_ready_r;

    // Stage-2 adder with two's-complement overflow detection.
    always_comb begin
        pp_ext_s  = ACC_W'(pp_r);
        sum_s     = acc_r + pp_ext_s;
        add_ovf_s = 1'b0;
        if ((acc_r[ACC_W-1] == pp_ext_s[ACC_W-1]) && (sum_s[ACC_W-1] != acc_r[ACC_W-1])) begin
            add_ovf_s = 1'b1;
        end else begin
            add_ovf_s = 1'b0;
        end
    end

    // Group control FSM with the two-stage multiply/accumulate pipeline.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= IDLE;
            in_ready_r   <= 1'b0;
            out_valid_r  <= 1'b0;
            acc_r        <= '0;
            ovf_r        <= 1'b0;
            term_count_r <= 16'd0;
            pp_r         <= '0;
            pp_valid_r   <= 1'b0;
            pp_last_r    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        state_r      <= ACCUM;
                        in_ready_r   <= 1'b1;
                        acc_r        <= '0;
                        ovf_r        <= 1'b0;
                        term_count_r <= 16'd0;
                        pp_valid_r   <= 1'b0;
                        pp_last_r    <= 1'b0;
                    end
                end
                ACCUM: begin
                    pp_valid_r <= accept_s;
                    pp_last_r  <= accept_s & in_last;
                    if (accept_s) begin
                        pp_r <= term_product(act, sign, exp, mantissa, bsig);
                        if (term_count_r != 16'hFFFF) begin
                            term_count_r <= term_count_r + 16'd1;
                        end
                        if (in_last) begin
                            in_ready_r <= 1'b0;
                        end
                    end
                    if (pp_valid_r) begin
                        acc_r <= sum_s;
                        if (add_ovf_s) begin
                            ovf_r <= 1'b1;
                        end
                        if (pp_last_r) begin
                            state_r     <= DONE;
                            out_valid_r <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_r     <= IDLE;
                        out_valid_r <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    in_ready_r  <= 1'b0;
                    out_valid_r <= 1'b0;
                    pp_valid_r  <= 1'b0;
                    pp_last_r   <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_r;
    assign out_valid  = out_valid_r;
    assign result     = acc_r;
    assign ovf        = ovf_r;
    assign term_count = term_count_r;

endmodule

// File: tb/tb_serial_term_accumulator.sv
// Directed and randomized bench for serial_term_accumulator, checked against
// an arithmetic reference model of the term sum.
module tb_serial_term_accumulator;

    localparam int ACT_W = 8;
    localparam int ACC_W = 24;
    localparam longint MAXV = (longint'(1) <<< (ACC_W - 1)) - 1;
    localparam longint MINV = -(longint'(1) <<< (ACC_W - 1));
    localparam longint SPAN = longint'(1) <<< ACC_W;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    start;
    logic                    in_valid;
    logic                    in_ready;
    logic                    in_last;
    logic                    sign;
    logic [1:0]              exp;
    logic                    mantissa;
    logic [2:0]              bsig;
    logic signed [ACT_W-1:0] act;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [ACC_W-1:0] result;
    logic                    ovf;
    logic [15:0]             term_count;

    int     checks   = 0;
    int     failures = 0;
    longint m_acc;
    longint m_ovf;
    longint m_cnt;

    serial_term_accumulator #(.ACT_W(ACT_W), .ACC_W(ACC_W)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
        .in_ready(in_ready), .in_last(in_last), .sign(sign), .exp(exp),
        .mantissa(mantissa), .bsig(bsig), .act(act), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .ovf(ovf), .term_count(term_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [63:0] obs, input longint expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: true integer sum, wrapped to ACC_W; overflow whenever the
    // unwrapped step leaves the signed range.
    task automatic model_add(input longint a, input bit s, input int e, input bit m, input int b);
        longint v;
        longint t;
        v = m ? a * (longint'(1) <<< (e + b)) : 0;
        if (s) v = -v;
        t = m_acc + v;
        if (t > MAXV || t < MINV) m_ovf = 1;
        while (t > MAXV) t -= SPAN;
        while (t < MINV) t += SPAN;
        m_acc = t;
        if (m_cnt < 65535) m_cnt++;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        m_acc = 0;
        m_ovf = 0;
        m_cnt = 0;
        check("start_in_ready", in_ready, 1);
    endtask

    task automatic send(input logic signed [ACT_W-1:0] a, input bit s, input int e,
                        input bit m, input int b, input bit last, input int gap);
        int w;
        repeat (gap) tick();
        w = 0;
        while (!in_ready && w < 20) begin
            tick();
            w++;
        end
        if (w == 20) check("in_ready_timeout", in_ready, 1);
        act      = a;
        sign     = s;
        exp      = 2'(e);
        mantissa = m;
        bsig     = 3'(b);
        in_last  = last;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        model_add(longint'(a), s, e, m, b);
    endtask

    task automatic wait_done(input string tag);
        int w;
        w = 0;
        while (!out_valid && w < 10) begin
            tick();
            w++;
        end
        check({tag, "_out_valid"}, out_valid, 1);
    endtask

    task automatic check_model(input string tag);
        check({tag, "_result"}, result, m_acc);
        check({tag, "_ovf"}, ovf, m_ovf);
        check({tag, "_count"}, term_count, m_cnt);
    endtask

    task automatic finish_out(input string tag, input int bp);
        repeat (bp) begin
            tick();
            check({tag, "_hold"}, out_valid, 1);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_out_drop"}, out_valid, 0);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        sign = 1'b0; exp = 2'd0; mantissa = 1'b0; bsig = 3'd0; act = '0;
        out_ready = 1'b0;
        m_acc = 0; m_ovf = 0; m_cnt = 0;
        tick();
        tick();
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_ovf", ovf, 0);
        check("rst_count", term_count, 0);
        reset = 1'b1;
        tick();

        // Weight 3 decomposition, act = 5, exact 2-cycle latency
        do_start();
        send(8'sd5, 1'b1, 0, 1'b1, 0, 1'b0, 0);
        send(8'sd5, 1'b0, 0, 1'b1, 2, 1'b0, 0);
        send(8'sd5, 1'b0, 0, 1'b0, 4, 1'b0, 0);
        send(8'sd5, 1'b0, 0, 1'b0, 6, 1'b1, 0);
        check("t1_in_ready_drop", in_ready, 0);
        check("t1_valid_early", out_valid, 0);
        tick();
        check("t1_valid_lat2", out_valid, 1);
        check("t1_result", result, 15);
        check("t1_ovf", ovf, 0);
        check("t1_count", term_count, 4);
        check_model("t1");
        finish_out("t1", 0);

        // Single-term group
        do_start();
        send(-8'sd3, 1'b1, 1, 1'b1, 0, 1'b1, 0);
        check("t2_in_ready_drop", in_ready, 0);
        wait_done("t2");
        check("t2_result", result, 6);
        check("t2_count", term_count, 1);
        finish_out("t2", 0);

        // Overflow boundary
        do_start();
        for (int i = 0; i < 64; i++) send(8'sh80, 1'b0, 3, 1'b1, 7, 1'b0, 0);
        tick();
        tick();
        check("t3_res64", result, -8388608);
        check("t3_ovf64", ovf, 0);
        check("t3_cnt64", term_count, 64);
        send(8'sh80, 1'b0, 3, 1'b1, 7, 1'b1, 0);
        wait_done("t3");
        check("t3_res65", result, 8257536);
        check("t3_ovf65", ovf, 1);
        check("t3_cnt65", term_count, 65);
        check_model("t3");

        // Backpressure in DONE with start pulsing, including on the handshake
        for (int i = 0; i < 5; i++) begin
            start = 1'b1;
            tick();
            check("bp_out_valid", out_valid, 1);
            check("bp_result", result, 8257536);
            check("bp_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        start = 1'b0;
        check("bp_out_drop", out_valid, 0);
        tick();
        check("bp_start_ignored", in_ready, 0);

        // Bubbles between terms
        do_start();
        send(8'sd5, 1'b1, 0, 1'b1, 0, 1'b0, 1);
        send(8'sd5, 1'b0, 0, 1'b1, 2, 1'b0, 1);
        send(8'sd5, 1'b0, 0, 1'b0, 4, 1'b0, 1);
        send(8'sd5, 1'b0, 0, 1'b0, 6, 1'b1, 1);
        wait_done("t5");
        check("t5_result", result, 15);
        check("t5_count", term_count, 4);
        finish_out("t5", 2);

        // Reset mid-group, then a fresh group
        do_start();
        send(8'sd5, 1'b0, 1, 1'b1, 0, 1'b0, 0);
        send(8'sd5, 1'b0, 2, 1'b1, 0, 1'b0, 0);
        reset = 1'b0;
        #1;
        check("mr_in_ready", in_ready, 0);
        check("mr_out_valid", out_valid, 0);
        check("mr_result", result, 0);
        check("mr_ovf", ovf, 0);
        check("mr_count", term_count, 0);
        tick();
        reset = 1'b1;
        tick();
        check("mr_idle", in_ready, 0);
        do_start();
        send(8'sd2, 1'b0, 2, 1'b1, 0, 1'b1, 0);
        wait_done("t6");
        check("t6_result", result, 8);
        check_model("t6");
        finish_out("t6", 0);

        // Randomized groups against the reference model
        for (int g = 0; g < 10; g++) begin
            int n;
            logic signed [ACT_W-1:0] a;
            do_start();
            n = $urandom_range(1, 40);
            for (int i = 0; i < n; i++) begin
                a = ACT_W'($urandom);
                send(a, 1'($urandom), $urandom_range(0, 3), 1'($urandom), $urandom_range(0, 7),
                     (i == n - 1), $urandom_range(0, 1));
            end
            wait_done("rnd");
            check_model("rnd");
            finish_out("rnd", $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
